// File: rtl/data_memory_pkg.sv
// Shared definitions for the data memory and the CPU datapath that uses it:
// default word/address widths, the matching typedefs, and a helper that
// sizes the storage index from the implemented depth.
package data_memory_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 16;

  typedef logic [DEF_DATA_WIDTH-1:0] word_t;
  typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;

  // Number of address bits needed to index DEPTH words (at least one bit).
  function automatic int index_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Memory access bus: one address, write data, write strobe and registered
// read data. The master (CPU or bench) drives the request, the slave
// (data_memory) returns dataOut.
interface data_memory_if
  import data_memory_pkg::*;
#(
  parameter int DW = DEF_DATA_WIDTH,
  parameter int AW = DEF_ADDR_WIDTH
) ();

  logic [AW-1:0] memAddress;
  logic [DW-1:0] dataIn;
  logic          writeEnable;
  logic [DW-1:0] dataOut;

  modport master (
    output memAddress,
    output dataIn,
    output writeEnable,
    input  dataOut
  );

  modport slave (
    input  memAddress,
    input  dataIn,
    input  writeEnable,
    output dataOut
  );

endinterface

// File: rtl/data_memory_ram_array.sv
// Pure storage core: one write port and one synchronous read port sharing
// the same address. The read returns the pre-write contents on a write
// cycle; the caller provides any write-first bypass. No reset on purpose,
// so the array maps onto block RAM and survives a system reset.
module ram_array #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 16,
  parameter int DEPTH      = 65536
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [IDX_WIDTH-1:0]  i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Single-port RAM: optional write plus registered read every edge.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory.sv
// Word-addressed single-port data memory with one-cycle registered output
// and write-first behaviour. The low index bits of the address select the
// word, so addresses beyond DEPTH alias. Reset clears only the output path
// and blocks writes; stored words are preserved.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  data_memory_if.slave bus
);

  localparam int IDX_W = index_width(DEPTH);

  logic [IDX_W-1:0]      w_index;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_ram_q;

  // Output-side state. The RAM read register itself carries no reset, so
  // r_valid is what forces dataOut to zero asynchronously; r_was_write and
  // r_wdata implement the write-first bypass for the access just taken.
  logic                  r_valid;
  logic                  r_was_write;
  logic [DATA_WIDTH-1:0] r_wdata;

  // Truncate the address to the implemented depth (wrap/alias upper bits).
  assign w_index = bus.memAddress[IDX_W-1:0];

  // Writes are blocked for any edge that sees reset high.
  assign w_wr_en = bus.writeEnable & ~reset;

  ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_W),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_addr  (w_index),
    .i_wdata (bus.dataIn),
    .o_rdata (w_ram_q)
  );

  // Capture the kind of access taken this edge; reset drops it immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_was_write <= 1'b0;
      r_wdata     <= '0;
    end else begin
      r_valid     <= 1'b1;
      r_was_write <= bus.writeEnable;
      r_wdata     <= bus.dataIn;
    end
  end

  // Write-first mux: a write returns its own data, a read returns the RAM.
  assign bus.dataOut = !r_valid    ? '0      :
                       r_was_write ? r_wdata :
                                     w_ram_q;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: a table of directed accesses with explicit expected
// outputs, hand-written reset and address-wrap sequences, and a random soak
// checked against a reference array model through a scoreboard queue.
module tb_data_memory;

  logic clk;
  logic reset;

  data_memory_if #(.DW(16), .AW(16)) m_if ();
  data_memory_if #(.DW(16), .AW(16)) w_if ();

  data_memory u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (m_if)
  );

  data_memory #(.DEPTH(256)) u_dut_w (
    .clk   (clk),
    .reset (reset),
    .bus   (w_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] exp;
    bit          care;
    string       name;
  } sb_t;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] exp;
    string       name;
  } vec_t;

  sb_t         sb_q[$];
  logic [15:0] model [int];
  vec_t        vecs [15];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: dataOut=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s: dataOut=%h", name, act);
    end
  endtask

  // One access on the main DUT: drive at negedge, queue the expectation,
  // take the edge, then pop and compare 1 ns later.
  task automatic drive(input bit we, input logic [15:0] a, input logic [15:0] d,
                       input string name, input bit care, input logic [15:0] exp);
    sb_t e;
    @(negedge clk);
    m_if.writeEnable = we;
    m_if.memAddress  = a;
    m_if.dataIn      = d;
    sb_q.push_back('{exp: exp, care: care, name: name});
    if (we && !reset) model[int'(a)] = d;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    if (e.care) check(e.name, m_if.dataOut, e.exp);
    else $display("skip %s: unwritten location, dataOut=%h", e.name, m_if.dataOut);
  endtask

  task automatic drive_w(input bit we, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    w_if.writeEnable = we;
    w_if.memAddress  = a;
    w_if.dataIn      = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          we;
    logic [15:0] a, d, exp;
    bit          care;

    vecs[0]  = '{1'b1, 16'h0000, 16'd100,  16'd100,  "wr_a0_100"};
    vecs[1]  = '{1'b1, 16'h0008, 16'd200,  16'd200,  "wr_a8_200"};
    vecs[2]  = '{1'b0, 16'h0000, 16'd200,  16'd100,  "rd_a0"};
    vecs[3]  = '{1'b0, 16'h0008, 16'd400,  16'd200,  "rd_a8"};
    vecs[4]  = '{1'b1, 16'h0005, 16'h1234, 16'h1234, "wr_a5_1234"};
    vecs[5]  = '{1'b1, 16'h0005, 16'hABCD, 16'hABCD, "wr_first_a5"};
    vecs[6]  = '{1'b0, 16'h0005, 16'h0000, 16'hABCD, "rd_a5"};
    vecs[7]  = '{1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, "wr_top"};
    vecs[8]  = '{1'b1, 16'h0000, 16'h0001, 16'h0001, "wr_bottom"};
    vecs[9]  = '{1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, "rd_top"};
    vecs[10] = '{1'b0, 16'h0000, 16'h0000, 16'h0001, "rd_bottom"};
    vecs[11] = '{1'b1, 16'h0007, 16'h0003, 16'h0003, "wr_a7_3"};
    vecs[12] = '{1'b1, 16'h0007, 16'h0004, 16'h0004, "wr_a7_4"};
    vecs[13] = '{1'b0, 16'h0007, 16'h0000, 16'h0004, "rd_a7_last"};
    vecs[14] = '{1'b0, 16'h0008, 16'h0000, 16'd200,  "rd_a8_unchanged"};

    m_if.writeEnable = 1'b0; m_if.memAddress = '0; m_if.dataIn = '0;
    w_if.writeEnable = 1'b0; w_if.memAddress = '0; w_if.dataIn = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_main", m_if.dataOut, 16'h0000);
    check("reset_wrap", w_if.dataOut, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 15; i++)
      drive(vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].name, 1'b1, vecs[i].exp);

    // Reset mid-stream: async clear, suppressed write, contents preserved.
    drive(1'b1, 16'h0010, 16'h00FF, "pre_rst_wr", 1'b1, 16'h00FF);
    #2 reset = 1'b1;
    #1 check("rst_async_clear", m_if.dataOut, 16'h0000);
    drive(1'b1, 16'h0010, 16'hBEEF, "wr_during_rst", 1'b1, 16'h0000);
    @(negedge clk);
    m_if.writeEnable = 1'b0;
    m_if.memAddress  = 16'h0010;
    reset = 1'b0;
    #1 check("rst_release_hold", m_if.dataOut, 16'h0000);
    @(posedge clk);
    #1 check("first_after_rst", m_if.dataOut, 16'h00FF);
    drive(1'b0, 16'h0000, 16'h0000, "rd_a0_after_rst", 1'b1, 16'h0001);

    // Address wrap on the 256-word instance.
    drive_w(1'b1, 16'h0105, 16'h5A5A);
    check("wrap_wr_0105", w_if.dataOut, 16'h5A5A);
    drive_w(1'b0, 16'h0005, 16'h0000);
    check("wrap_rd_0005", w_if.dataOut, 16'h5A5A);
    drive_w(1'b1, 16'h0006, 16'h1111);
    drive_w(1'b0, 16'hFF06, 16'h0000);
    check("wrap_rd_ff06", w_if.dataOut, 16'h1111);

    // Random soak against the reference model.
    for (int i = 0; i < 10000; i++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(0, 65535));
      else a = 16'($urandom_range(0, 63));
      d = 16'($urandom_range(0, 65535));
      if (we) begin
        exp = d; care = 1'b1;
      end else if (model.exists(int'(a))) begin
        exp = model[int'(a)]; care = 1'b1;
      end else begin
        exp = '0; care = 1'b0;
      end
      drive(we, a, d, $sformatf("soak%0d_%s_%h", i, we ? "wr" : "rd", a), care, exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
